// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell,
// one borrow flop, LSB first, with a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_nxt;
    logic             a_msb;
    logic             b_msb;
    logic             x;
    logic             y;
    logic             d;
    logic             accept;

    assign x       = a_sr[0];
    assign y       = b_sr[0];
    assign d       = x ^ y ^ br;
    assign br_nxt  = (~x & y) | (~(x ^ y) & br);
    assign res_nxt = {d, res[WIDTH-1:1]};

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign accept = start & ((state == IDLE) | (state == DONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= res_nxt;
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    // Last bit: publish the assembled word in one step
                    if (cnt == LAST) begin
                        state      <= DONE;
                        diff       <= res_nxt;
                        borrow_out <= br_nxt;
                        overflow   <= (a_msb != b_msb) &
                                      (res_nxt[WIDTH-1] != a_msb);
                        zero       <= ~|res_nxt;
                    end
                end
                default: begin
                    if (accept) begin
                        state <= SHIFT;
                        a_sr  <= a;
                        b_sr  <= b;
                        res   <= '0;
                        cnt   <= '0;
                        br    <= 1'b0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
